nibble_add_seq: RTL and testbench
=================================

Name: nibble_add_seq

Overview:
- Multi-cycle controller that performs a wide add by sequencing one shared 4-bit nibble adder slice, least-significant nibble first.
- The carry is chained between cycles through a register.
- Sits between a requester, using a start/busy/done handshake, and the nibble adder datapath. Trades latency for a single 4-bit adder.

Parameters:
- NIBBLES, 2, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES. Legal range 1..8.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  W  operand A; sampled when start is accepted
- b  in  W  operand B; sampled when start is accepted
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when sum/cout become valid
- sum  out  W  result; held until the next accepted start
- cout  out  1  carry out of the most significant nibble

Behaviour:
- Reset:
  - Interface is a single clock; reset is synchronous and active-high.
  - On rst=1 at a rising edge: state=IDLE, busy=0, done=0, sum=0, cout=0, nibble index=0, carry register=0, operand registers=0.
  - Reset has priority over everything, including mid-operation: the operation is aborted and no done is produced.
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - If start=1 at an edge: latch a and b into operand registers, clear the carry register, set index=0, go to RUN, busy=1.
  - If start=0: remain in IDLE.
- RUN, one nibble per edge:
  - {c, s} = A[4i+3:4i] + B[4i+3:4i] + carry_reg, a 5-bit result.
  - Write s into sum[4i+3:4i], set carry_reg=c, index=i+1.
  - On the edge that processes nibble NIBBLES-1: cout=c, done=1 for the following cycle only, busy=0, state=IDLE, index=0.
- Latency:
  - With start accepted at edge E0, done is high in the cycle after edge E(NIBBLES). That is 3 edges for the default NIBBLES=2.
  - Throughput is one operation per NIBBLES+1 cycles.
- start while busy=1 is ignored. Operands, result and timing are unaffected; no queuing.
- start=1 in the cycle where done=1 (state already IDLE) is accepted:
  - done drops next cycle and busy rises.
  - sum and cout keep their old values until the first RUN edge overwrites sum's low nibble.
- Intermediate values:
  - sum is partially updated during RUN.
  - Consumers must only sample sum/cout when done=1 or after it while busy=0.
- Changes on a or b after acceptance do not affect the result.
- Width rule: all arithmetic is modulo 2^W; the carry beyond the MSB goes only to cout.

Optional Feature:
- Macro: NIBBLE_ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port `sub` (1 bit), sampled with a and b at start acceptance.
  - When sub=1, the operand B register is loaded with ~b and the carry register is initialised to 1, giving sum = A - B mod 2^W.
  - cout=1 means no borrow (A >= B unsigned).
  - sub=0 behaves exactly as the base block.
- Not defined:
  - No `sub` port; add only; the carry register is always initialised to 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> busy=0, done=0, sum=0x00, cout=0; then start=0 for 5 cycles -> outputs unchanged.
- Basic add and latency (NIBBLES=2):
  - a=0x24, b=0x81, start pulse at E0 -> busy high after E0, done high only in the cycle after E2, sum=0xA5, cout=0.
  - a=0x0d, b=0x8d -> sum=0x9A, cout=0; checks the inter-nibble carry.
- Carry out and wrap:
  - a=0xed, b=0x8c -> sum=0x79, cout=1.
  - a=0xff, b=0x01 -> sum=0x00, cout=1.
- Handshake edge cases:
  - Pulse start with a=0x11, b=0x22 one cycle after accepting a=0x09, b=0x63 -> ignored; done once with sum=0x6C, cout=0.
  - Start held high through done -> back-to-back operation accepted, second done exactly 3 cycles after the first.
- Reset mid-operation: accept a=0xf9, b=0xc6, assert rst after E1 -> no done pulse ever, busy=0, sum=0x00, cout=0; the next operation runs normally.
- With NIBBLE_ADD_SEQ_SUB_EN:
  - sub=1, a=0x76, b=0x3d -> sum=0x39, cout=1.
  - sub=1, a=0x12, b=0x88 -> sum=0x8A, cout=0.
  - sub=0, a=0xc5, b=0xaa -> sum=0x6F, cout=1.

Source files
------------

// File: rtl/nibble_add_seq_if.sv
// Requester <-> nibble_add_seq handshake bundle.
//   master : requester side (drives start/a/b[/sub], observes busy/done/sum/cout)
//   slave  : controller side
// Optional macro NIBBLE_ADD_SEQ_SUB_EN adds the 1-bit 'sub' request field.
interface nibble_add_seq_if #(
    parameter int unsigned NIBBLES = 2
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_add_seq.sv
// Wide adder built from one shared 4-bit slice, LS nibble first, carry chained
// through a register between cycles. One result per NIBBLES+1 cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any operation, no done)
//   bus  - nibble_add_seq_if.slave: start/a/b[/sub] in, busy/done/sum/cout out
// Optional macro NIBBLE_ADD_SEQ_SUB_EN: 'sub' request loads ~b and carry-in 1,
// giving A - B mod 2^W with cout=1 meaning no borrow.
module nibble_add_seq #(
    parameter int unsigned NIBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_add_seq_if.slave      bus
);
    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;

    logic [IDX_W+1:0] nib_off_c;
    logic [4:0]       nib_sum_c;
    logic             last_c;

    // Shared nibble slice: current nibble of A + B + chained carry.
    always_comb begin
        nib_off_c = {idx_q, 2'b00};
        nib_sum_c = 5'(a_q[nib_off_c +: 4]) + 5'(b_q[nib_off_c +: 4]) + 5'(carry_q);
        last_c    = (idx_q == IDX_W'(NIBBLES - 1));
    end

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    a_d     = bus.a;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
                    // Subtract as A + ~B + 1.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
`else
                    b_d     = bus.b;
                    carry_d = 1'b0;
`endif
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[nib_off_c +: 4] = nib_sum_c[3:0];
                carry_d               = nib_sum_c[4];
                if (last_c) begin
                    cout_d  = nib_sum_c[4];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: directed plan vectors, randomized
// operations against an arithmetic reference model, and handshake corner cases.
module tb_nibble_add_seq;
    localparam int unsigned NIBBLES = 2;
    localparam int unsigned W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nibble_add_seq_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain (W+1)-bit arithmetic; subtract is A + ~B + 1.
    function automatic logic [W:0] ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic sv);
        logic [W:0] r;
        if (sv) r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        else    r = {1'b0, av} + {1'b0, bv};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic sv);
        bus.start = st;
        bus.a     = av;
        bus.b     = bv;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        bus.sub   = sv;
`endif
    endtask

    // One complete operation: accept, scramble inputs, check latency and result.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input string tag);
        logic [W:0] exp_r;
        int         edges;
        exp_r = ref_op(av, bv, sv);
        set_req(1'b1, av, bv, sv);
        tick();
        set_req(1'b0, W'($urandom), W'($urandom), 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", tag, bus.busy, bus.done);
            n_err++;
        end
        edges = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        n_cmp++;
        if (edges !== NIBBLES) begin
            $display("FAIL %s latency: %0d edges after accept, required %0d", tag, edges, NIBBLES);
            n_err++;
        end
        n_cmp++;
        if ({bus.cout, bus.sum} !== exp_r || bus.busy !== 1'b0) begin
            $display("FAIL %s result: cout=%b sum=%h busy=%b required cout=%b sum=%h busy=0",
                     tag, bus.cout, bus.sum, bus.busy, exp_r[W], exp_r[W-1:0]);
            n_err++;
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || {bus.cout, bus.sum} !== exp_r) begin
            $display("FAIL %s hold: done=%b cout=%b sum=%h required done=0 cout=%b sum=%h",
                     tag, bus.done, bus.cout, bus.sum, exp_r[W], exp_r[W-1:0]);
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== W'(0) || bus.cout !== 1'b0) begin
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b required all zero",
                     bus.busy, bus.done, bus.sum, bus.cout);
            n_err++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== W'(0) || bus.cout !== 1'b0) begin
                $display("FAIL idle[%0d]: busy=%b done=%b sum=%h cout=%b required all zero",
                         i, bus.busy, bus.done, bus.sum, bus.cout);
                n_err++;
            end
        end
    endtask

    task automatic test_directed();
        run_op(8'h24, 8'h81, 1'b0, "add_24_81");
        run_op(8'h0d, 8'h8d, 1'b0, "add_0d_8d");
        run_op(8'hed, 8'h8c, 1'b0, "add_ed_8c");
        run_op(8'hff, 8'h01, 1'b0, "add_ff_01");
    endtask

    task automatic test_random();
        logic sv;
        for (int i = 0; i < 24; i++) begin
            sv = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            sv = 1'($urandom_range(0, 1));
`endif
            run_op(W'($urandom), W'($urandom), sv, "random");
        end
    endtask

    task automatic test_ignore_start();
        int n_done;
        set_req(1'b1, 8'h09, 8'h63, 1'b0);
        tick();
        set_req(1'b1, 8'h11, 8'h22, 1'b0);
        tick();
        set_req(1'b0, 8'h11, 8'h22, 1'b0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) begin
                n_done++;
                n_cmp++;
                if (bus.sum !== 8'h6C || bus.cout !== 1'b0) begin
                    $display("FAIL ignore_start result: sum=%h cout=%b required sum=6c cout=0",
                             bus.sum, bus.cout);
                    n_err++;
                end
            end
            tick();
        end
        n_cmp++;
        if (n_done !== 1) begin
            $display("FAIL ignore_start done count: %0d required 1", n_done);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp1, exp2;
        int         edges;
        exp1 = ref_op(8'h37, 8'h5a, 1'b0);
        exp2 = ref_op(8'hc3, 8'h7e, 1'b0);
        set_req(1'b1, 8'h37, 8'h5a, 1'b0);
        tick();
        // Second operands presented while busy: must not disturb the first result.
        set_req(1'b1, 8'hc3, 8'h7e, 1'b0);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        n_cmp++;
        if (edges !== NIBBLES || {bus.cout, bus.sum} !== exp1) begin
            $display("FAIL b2b first: edges=%0d cout=%b sum=%h required edges=%0d cout=%b sum=%h",
                     edges, bus.cout, bus.sum, NIBBLES, exp1[W], exp1[W-1:0]);
            n_err++;
        end
        tick();
        set_req(1'b0, 8'h00, 8'h00, 1'b0);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || {bus.cout, bus.sum} !== exp1) begin
            $display("FAIL b2b reaccept: done=%b busy=%b cout=%b sum=%h required done=0 busy=1 cout=%b sum=%h",
                     bus.done, bus.busy, bus.cout, bus.sum, exp1[W], exp1[W-1:0]);
            n_err++;
        end
        edges = 1;
        while (bus.done !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        n_cmp++;
        if (edges !== NIBBLES + 1 || {bus.cout, bus.sum} !== exp2) begin
            $display("FAIL b2b second: spacing=%0d cout=%b sum=%h required spacing=%0d cout=%b sum=%h",
                     edges, bus.cout, bus.sum, NIBBLES + 1, exp2[W], exp2[W-1:0]);
            n_err++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n_done;
        set_req(1'b1, 8'hf9, 8'hc6, 1'b0);
        tick();
        set_req(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        n_cmp++;
        if (n_done !== 0 || bus.busy !== 1'b0 || bus.sum !== W'(0) || bus.cout !== 1'b0) begin
            $display("FAIL reset_mid: dones=%0d busy=%b sum=%h cout=%b required 0/0/00/0",
                     n_done, bus.busy, bus.sum, bus.cout);
            n_err++;
        end
        run_op(8'h5a, 8'h3c, 1'b0, "after_reset");
    endtask

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    task automatic test_sub();
        run_op(8'h76, 8'h3d, 1'b1, "sub_76_3d");
        run_op(8'h12, 8'h88, 1'b1, "sub_12_88");
        run_op(8'hc5, 8'haa, 1'b0, "add_c5_aa");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
